spm_serial_mult: RTL and testbench

SPM_SERIAL_MULT -- requirements
Module: spm_serial_mult

---
 rtl/spm_pkg.sv | 22 ++
 rtl/spm_cell.sv | 42 ++++
 rtl/spm_serial_mult.sv | 142 ++++++++++++++
 tb/tb_spm_serial_mult.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier: default widths,
// FSM state encoding and the bit-counter width helper.
// Optional feature macro: SPM_PARALLEL_OUT_EN (see spm_serial_mult).
package spm_pkg;

  localparam int unsigned A_W_DEF = 8;
  localparam int unsigned P_W_DEF = 2 * A_W_DEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } spm_state_e;

  // Counter must represent 0..p_w inclusive
  function automatic int unsigned cnt_width(input int unsigned p_w);
    return $clog2(p_w + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(P_W_DEF);

endpackage

// File: rtl/spm_cell.sv
// One carry-save full-adder cell of the serial-parallel multiplier array.
// Holds its own sum and carry bits; s_nxt exposes the pre-register sum.
module spm_cell
  import spm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pp,
  input  logic s_in,
  output logic s_nxt,
  output logic s
);

  logic s_q;
  logic c_q;
  logic c_nxt;

  // Full adder of partial product, sum from the cell above and own carry
  always_comb begin
    s_nxt = pp ^ s_in ^ c_q;
    c_nxt = (pp & s_in) | (pp & c_q) | (s_in & c_q);
  end

  // Sum/carry state: cleared on a new operation, advanced only while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (clr) begin
      s_q <= 1'b0;
      c_q <= 1'b0;
    end else if (en) begin
      s_q <= s_nxt;
      c_q <= c_nxt;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/spm_serial_mult.sv
// Serial-parallel signed multiplier: parallel multiplicand a, serial
// multiplier LSB first, serial product LSB first with one cycle latency.
// Define SPM_PARALLEL_OUT_EN to also assemble the product in parallel.
//
// Signed a is handled by negating the MSB partial product: each cycle the
// MSB cell adds ~(a_msb & x) and a single +1 at weight 2^(A_W-1) is injected
// on the first RUN cycle; modulo 2^P_W this equals the two's-complement sum.
module spm_serial_mult
  import spm_pkg::*;
#(
  parameter int unsigned A_W = A_W_DEF,
  parameter int unsigned P_W = 2 * A_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic           ser_in,
  output logic           shift_req,
  output logic           prod_bit,
  output logic           prod_valid,
  output logic [P_W-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = cnt_width(P_W);

  spm_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]  a_q;
  logic            valid_q;

  logic            accept;
  logic            run;
  logic            last_bit;
  logic            inject;
  logic [A_W-1:0]  pp;
  logic [A_W-1:0]  s_vec;
  logic [A_W-1:0]  s_nxt_vec;

  assign accept   = (state_q == StIdle) & start;
  assign run      = (state_q == StRun);
  assign last_bit = (cnt_q == CntW'(P_W - 1));
  assign inject   = run & (cnt_q == '0);

  // Next-state and bit counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (last_bit) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counter, latched multiplicand and output-valid registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= run;
      if (accept) a_q <= a;
    end
  end

  // Carry-save cell array; sums ripple one cell toward the LSB per cycle
  for (genvar i = 0; i < A_W; i++) begin : g_cell
    if (i == A_W - 1) begin : g_msb
      assign pp[i] = ~(a_q[i] & ser_in);
      spm_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (run),
        .pp    (pp[i]),
        .s_in  (inject),
        .s_nxt (s_nxt_vec[i]),
        .s     (s_vec[i])
      );
    end else begin : g_lsb
      assign pp[i] = a_q[i] & ser_in;
      spm_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .en    (run),
        .pp    (pp[i]),
        .s_in  (s_vec[i+1]),
        .s_nxt (s_nxt_vec[i]),
        .s     (s_vec[i])
      );
    end
  end

  // Cell 0's registered sum is the serial product bit
  assign prod_bit   = s_vec[0];
  assign prod_valid = valid_q;
  assign shift_req  = run;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

`ifdef SPM_PARALLEL_OUT_EN
  logic [P_W-1:0] prod_q;
  logic           unused_s_nxt;

  // Collect product bits MSB-side first so the word is complete in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
    end else if (accept) begin
      prod_q <= '0;
    end else if (run) begin
      prod_q <= {s_nxt_vec[0], prod_q[P_W-1:1]};
    end
  end

  assign product      = prod_q;
  assign unused_s_nxt = ^s_nxt_vec[A_W-1:1];
`else
  logic unused_s_nxt;

  assign product      = '0;
  assign unused_s_nxt = ^s_nxt_vec;
`endif

endmodule

// File: tb/tb_spm_serial_mult.sv
// Scoreboard bench for spm_serial_mult: stimulus pushes expected serial bits
// and final products; a negedge monitor pops and compares them.
module tb_spm_serial_mult;

  localparam int AW = 8;
  localparam int PW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] a;
  logic          ser_in;
  logic          shift_req;
  logic          prod_bit;
  logic          prod_valid;
  logic [PW-1:0] product;
  logic          busy;
  logic          done;

  int checks = 0;
  int passes = 0;

  bit            bitq[$];
  logic [PW-1:0] prodq[$];
  logic [PW-1:0] last_prod;

  spm_serial_mult #(
    .A_W (AW),
    .P_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .ser_in     (ser_in),
    .shift_req  (shift_req),
    .prod_bit   (prod_bit),
    .prod_valid (prod_valid),
    .product    (product),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every qualified output is popped from the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (prod_valid) begin
        if (bitq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_prod_valid: got 1, expected 0");
        end else begin
          chk("prod_bit", prod_bit, bitq.pop_front());
        end
      end
      if (done) begin
        if (prodq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got 1, expected 0");
        end else begin
          chk("product_at_done", product, prodq.pop_front());
        end
      end
    end
  end

  // Reference: plain signed multiply, truncated to PW bits
  function automatic logic [PW-1:0] ref_mult(input logic [AW-1:0] av, input logic [PW-1:0] yv);
    longint p;
    logic [63:0] pv;
    p  = longint'($signed(av)) * longint'($signed(yv));
    pv = p;
    return pv[PW-1:0];
  endfunction

  // One operation; rst_at >= 0 pulls reset during that RUN cycle index
  task automatic run_op(input logic [AW-1:0] av, input logic [PW-1:0] yv, input bit hold,
                        input int rst_at);
    logic [PW-1:0] exp_p;
    logic [PW-1:0] exp_word;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_prod_valid", prod_valid, 0);
    chk("idle_product_hold", product, last_prod);
    exp_p = ref_mult(av, yv);
`ifdef SPM_PARALLEL_OUT_EN
    exp_word = exp_p;
`else
    exp_word = '0;
`endif
    for (int k = 0; k < PW; k++) bitq.push_back(exp_p[k]);
    prodq.push_back(exp_word);
    start = 1'b1;
    a     = av;
    for (int k = 0; k < PW; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      a      = AW'($urandom);
      ser_in = yv[k];
      chk("shift_req_run", shift_req, 1);
      chk("busy_run", busy, 1);
      if (k == 0) chk("first_run_prod_valid", prod_valid, 0);
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1 chk("reset_abort_outputs", {shift_req, prod_bit, prod_valid, busy, done, product}, 0);
        bitq.delete();
        prodq.delete();
        last_prod = '0;
        start     = 1'b0;
        @(negedge clk);
        chk("no_done_in_reset", done, 0);
        #2 rst = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("shift_req_done", shift_req, 0);
    chk("prod_valid_done", prod_valid, 1);
    last_prod = exp_word;
  endtask

  initial begin
    logic [7:0]    b;
    logic [AW-1:0] ra;
    logic [PW-1:0] ry;
    rst       = 1'b0;
    start     = 1'b0;
    a         = '0;
    ser_in    = 1'b0;
    last_prod = '0;
    #3 chk("reset_outputs", {shift_req, prod_bit, prod_valid, busy, done, product}, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    run_op(8'd3,    16'h0005, 1'b0, -1);
    run_op(8'h80,   16'hFF80, 1'b0, -1);
    run_op(8'd127,  16'hFF80, 1'b0, -1);
    run_op(8'hFF,   16'h0001, 1'b0, -1);
    run_op(8'd5,    16'hFFFD, 1'b0, -1);
    run_op(8'h11,   16'h1234, 1'b0, 6);
    run_op(8'd2,    16'h0003, 1'b0, -1);
    run_op(8'hA5,   16'hFFC3, 1'b1, -1);
    run_op(8'h3C,   16'h0071, 1'b1, -1);
    run_op(8'h7E,   16'h8001, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      ra = AW'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) ry = {{8{b[7]}}, b};
      else ry = PW'($urandom);
      run_op(ra, ry, bit'($urandom_range(0, 1)), -1);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle_busy", busy, 0);
    chk("final_product_hold", product, last_prod);
    chk("bits_all_seen", bitq.size(), 0);
    chk("products_all_seen", prodq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
